// File: rtl/axi_txn_tracker_if.sv
// Handshake/flag bundle between the CPU-side AXI bridge and its phase tracker.
// Ports: AR/R/AW/W/B valid, ready and IDs plus err_clr in; phase and error flags out.
interface axi_txn_tracker_if;
    logic       arvalid;
    logic       arready;
    logic [3:0] arid;
    logic       rvalid;
    logic       rready;
    logic [3:0] rid;
    logic       awvalid;
    logic       awready;
    logic       wvalid;
    logic       wready;
    logic       bvalid;
    logic       bready;
    logic       err_clr;
    logic       inst_raddr_ok;
    logic       data_raddr_ok;
    logic       data_rdata_ok;
    logic       data_waddr_ok;
    logic       data_wdata_ok;
    logic       data_write_ok;
    logic       err_proto;
    logic       err_timeout;

    modport master (
        output arvalid, arready, arid,
        output rvalid, rready, rid,
        output awvalid, awready,
        output wvalid, wready,
        output bvalid, bready,
        output err_clr,
        input  inst_raddr_ok, data_raddr_ok, data_rdata_ok,
        input  data_waddr_ok, data_wdata_ok, data_write_ok,
        input  err_proto, err_timeout
    );

    modport slave (
        input  arvalid, arready, arid,
        input  rvalid, rready, rid,
        input  awvalid, awready,
        input  wvalid, wready,
        input  bvalid, bready,
        input  err_clr,
        output inst_raddr_ok, data_raddr_ok, data_rdata_ok,
        output data_waddr_ok, data_wdata_ok, data_write_ok,
        output err_proto, err_timeout
    );
endinterface

// File: rtl/axi_txn_tracker.sv
// AXI read/write phase tracker with per-side watchdog and sticky error flags.
// Ports: aclk, aresetn (async low), bus (slave modport of axi_txn_tracker_if).
module axi_txn_tracker #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    axi_txn_tracker_if.slave  bus
);
    typedef enum logic {RD_IDLE, RD_WAIT} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic             WD_ON   = (TIMEOUT != 0);

    rd_state_e        rd_q, rd_d;
    logic             rd_id_q, rd_id_d;
    wr_state_e        wr_q, wr_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             perr_q, perr_d;
    logic             terr_q, terr_d;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic rd_err, wr_err, rd_tmo, wr_tmo;
    logic unused_id_bits;

    assign ar_hs = bus.arvalid & bus.arready;
    assign r_hs  = bus.rvalid  & bus.rready;
    assign aw_hs = bus.awvalid & bus.awready;
    assign w_hs  = bus.wvalid  & bus.wready;
    assign b_hs  = bus.bvalid  & bus.bready;

    assign unused_id_bits = ^{bus.arid[3:1], bus.rid[3:1]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_q     <= RD_IDLE;
            rd_id_q  <= 1'b0;
            wr_q     <= WR_IDLE;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            perr_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            rd_id_q  <= rd_id_d;
            wr_q     <= wr_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            perr_q   <= perr_d;
            terr_q   <= terr_d;
        end
    end

    // Read side: a new AR while one is pending is only legal together
    // with the R that retires the pending one.
    always_comb begin
        rd_d    = rd_q;
        rd_id_d = rd_id_q;
        rd_err  = 1'b0;
        unique case (rd_q)
            RD_IDLE: begin
                if (r_hs) rd_err = 1'b1;
                if (ar_hs) begin
                    rd_d    = RD_WAIT;
                    rd_id_d = bus.arid[0];
                end
            end
            RD_WAIT: begin
                if (r_hs && (bus.rid[0] != rd_id_q)) rd_err = 1'b1;
                if (r_hs && ar_hs) begin
                    rd_id_d = bus.arid[0];
                end else if (r_hs) begin
                    rd_d = RD_IDLE;
                end else if (ar_hs) begin
                    rd_err = 1'b1;
                end
            end
            default: rd_d = RD_IDLE;
        endcase
    end

    // Write side: any handshake arriving in the wrong phase is flagged
    // and ignored; AW wins over a simultaneous W in idle.
    always_comb begin
        wr_d   = wr_q;
        wr_err = 1'b0;
        unique case (wr_q)
            WR_IDLE: begin
                if (w_hs || b_hs) wr_err = 1'b1;
                if (aw_hs) wr_d = WR_DATA;
            end
            WR_DATA: begin
                if (aw_hs || b_hs) wr_err = 1'b1;
                if (w_hs) wr_d = WR_RESP;
            end
            WR_RESP: begin
                if (aw_hs || w_hs) wr_err = 1'b1;
                if (b_hs) wr_d = WR_IDLE;
            end
            default: wr_d = WR_IDLE;
        endcase
    end

    // Watchdogs: count edges spent outstanding; fire once when the
    // count steps onto TIMEOUT.
    always_comb begin
        rd_cnt_d = '0;
        wr_cnt_d = '0;
        rd_tmo   = 1'b0;
        wr_tmo   = 1'b0;
        if (rd_q != RD_IDLE && rd_cnt_q != CNT_MAX) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            rd_tmo   = WD_ON && (rd_cnt_d == TMO);
        end else if (rd_q != RD_IDLE) begin
            rd_cnt_d = rd_cnt_q;
        end
        if (wr_q != WR_IDLE && wr_cnt_q != CNT_MAX) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            wr_tmo   = WD_ON && (wr_cnt_d == TMO);
        end else if (wr_q != WR_IDLE) begin
            wr_cnt_d = wr_cnt_q;
        end
    end

    // A new error event overrides a same-cycle clear.
    always_comb begin
        perr_d = (perr_q & ~bus.err_clr) | rd_err | wr_err;
        terr_d = (terr_q & ~bus.err_clr) | rd_tmo | wr_tmo;
    end

    assign bus.inst_raddr_ok = (rd_q == RD_WAIT) & ~rd_id_q;
    assign bus.data_raddr_ok = (rd_q == RD_WAIT) &  rd_id_q;
    assign bus.data_rdata_ok = ~((rd_q == RD_WAIT) & rd_id_q);
    assign bus.data_waddr_ok = (wr_q == WR_DATA);
    assign bus.data_wdata_ok = (wr_q == WR_RESP);
    assign bus.data_write_ok = (wr_q == WR_IDLE);
    assign bus.err_proto     = perr_q;
    assign bus.err_timeout   = terr_q;
endmodule

// File: tb/tb_axi_txn_tracker.sv
// Self-checking bench for axi_txn_tracker: vector table, corner
// sequences, and randomized traffic against a transaction-level model.
module tb_axi_txn_tracker;
    localparam int TMO = 8;

    typedef struct {
        logic [1:0] ar;
        logic [3:0] arid;
        logic [1:0] r;
        logic [3:0] rid;
        logic [1:0] aw;
        logic [1:0] w;
        logic [1:0] b;
        logic       clr;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [7:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    vec_t vecs[$];

    // outstanding-transaction model
    bit m_rbusy, m_rtag, m_proto, m_tmo;
    int m_rage, m_wph, m_wage;

    always #5 clk = ~clk;

    axi_txn_tracker_if bus();

    axi_txn_tracker #(.TIMEOUT(TMO), .CNT_W(16)) dut (
        .aclk(clk),
        .aresetn(rst_n),
        .bus(bus)
    );

    function automatic stim_t mk(logic [1:0] ar, logic [3:0] arid,
                                 logic [1:0] r, logic [3:0] rid,
                                 logic [1:0] aw, logic [1:0] w,
                                 logic [1:0] b, logic clr);
        stim_t s;
        s.ar = ar; s.arid = arid; s.r = r; s.rid = rid;
        s.aw = aw; s.w = w; s.b = b; s.clr = clr;
        return s;
    endfunction

    function automatic logic [7:0] outs();
        return {bus.inst_raddr_ok, bus.data_raddr_ok, bus.data_rdata_ok,
                bus.data_waddr_ok, bus.data_wdata_ok, bus.data_write_ok,
                bus.err_proto, bus.err_timeout};
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic apply(stim_t s);
        bus.arvalid = s.ar[1]; bus.arready = s.ar[0]; bus.arid = s.arid;
        bus.rvalid  = s.r[1];  bus.rready  = s.r[0];  bus.rid  = s.rid;
        bus.awvalid = s.aw[1]; bus.awready = s.aw[0];
        bus.wvalid  = s.w[1];  bus.wready  = s.w[0];
        bus.bvalid  = s.b[1];  bus.bready  = s.b[0];
        bus.err_clr = s.clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(string n, stim_t s, logic [7:0] e);
        vec_t v;
        v.s = s; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_rbusy = 0; m_rtag = 0; m_rage = 0;
        m_wph = 0; m_wage = 0; m_proto = 0; m_tmo = 0;
    endtask

    task automatic model_step(stim_t s);
        bit arh, rh, awh, wh, bh, ev, tev;
        arh = &s.ar; rh = &s.r; awh = &s.aw; wh = &s.w; bh = &s.b;
        ev = 0; tev = 0;
        if (m_rbusy) begin
            m_rage++;
            if (m_rage == TMO) tev = 1;
        end
        if (m_wph != 0) begin
            m_wage++;
            if (m_wage == TMO) tev = 1;
        end
        if (!m_rbusy) begin
            if (rh) ev = 1;
            if (arh) begin m_rbusy = 1; m_rtag = s.arid[0]; end
        end else begin
            if (rh && s.rid[0] != m_rtag) ev = 1;
            if (rh && arh) m_rtag = s.arid[0];
            else if (rh) m_rbusy = 0;
            else if (arh) ev = 1;
        end
        case (m_wph)
            0: begin if (wh || bh) ev = 1; if (awh) m_wph = 1; end
            1: begin if (awh || bh) ev = 1; if (wh) m_wph = 2; end
            default: begin if (awh || wh) ev = 1; if (bh) m_wph = 0; end
        endcase
        if (!m_rbusy) m_rage = 0;
        if (m_wph == 0) m_wage = 0;
        m_proto = ev | (m_proto & !s.clr);
        m_tmo = tev | (m_tmo & !s.clr);
    endtask

    function automatic logic [7:0] model_outs();
        return {m_rbusy & !m_rtag, m_rbusy & m_rtag, !(m_rbusy & m_rtag),
                m_wph == 1, m_wph == 2, m_wph == 0, m_proto, m_tmo};
    endfunction

    initial begin
        stim_t idle;
        stim_t s;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        apply(idle);
        rst_n = 1'b0;
        step();
        step();
        check("reset", outs(), 8'b0010_0100);
        #1 rst_n = 1'b1;

        add("idle",       idle,                                  8'b0010_0100);
        add("ar_inst",    mk(3, 0, 0, 0, 0, 0, 0, 0),            8'b1010_0100);
        add("ar_noready", mk(2, 0, 0, 0, 0, 0, 0, 0),            8'b1010_0100);
        add("r_inst",     mk(0, 0, 3, 0, 0, 0, 0, 0),            8'b0010_0100);
        add("aw",         mk(0, 0, 0, 0, 3, 0, 0, 0),            8'b0011_0000);
        add("w_noready",  mk(0, 0, 0, 0, 0, 2, 0, 0),            8'b0011_0000);
        add("w",          mk(0, 0, 0, 0, 0, 3, 0, 0),            8'b0010_1000);
        add("b_novalid",  mk(0, 0, 0, 0, 0, 0, 1, 0),            8'b0010_1000);
        add("b",          mk(0, 0, 0, 0, 0, 0, 3, 0),            8'b0010_0100);
        add("ar_data",    mk(3, 1, 0, 0, 0, 0, 0, 0),            8'b0100_0100);
        add("b2b_read",   mk(3, 0, 3, 1, 0, 0, 0, 0),            8'b1010_0100);
        add("rid_mism",   mk(0, 0, 3, 1, 0, 0, 0, 0),            8'b0010_0110);
        add("clr1",       mk(0, 0, 0, 0, 0, 0, 0, 1),            8'b0010_0100);
        add("w_in_idle",  mk(0, 0, 0, 0, 0, 3, 0, 0),            8'b0010_0110);
        add("clr_vs_err", mk(0, 0, 0, 0, 0, 0, 3, 1),            8'b0010_0110);
        add("clr2",       mk(0, 0, 0, 0, 0, 0, 0, 1),            8'b0010_0100);
        add("ar_id_e",    mk(3, 4'hE, 0, 0, 0, 0, 0, 0),         8'b1010_0100);
        add("ar_twice",   mk(3, 1, 0, 0, 0, 0, 0, 0),            8'b1010_0110);
        add("r_id2_clr",  mk(0, 0, 3, 4'h2, 0, 0, 0, 1),         8'b0010_0100);
        add("aw_w_same",  mk(0, 0, 0, 0, 3, 3, 0, 0),            8'b0011_0010);
        add("aw_in_data", mk(0, 0, 0, 0, 3, 0, 0, 1),            8'b0011_0010);
        add("w_resp",     mk(0, 0, 0, 0, 0, 3, 0, 0),            8'b0010_1010);
        add("b_clr",      mk(0, 0, 0, 0, 0, 0, 3, 1),            8'b0010_0100);
        add("r_in_idle",  mk(0, 0, 3, 0, 0, 0, 0, 0),            8'b0010_0110);
        add("clr3",       mk(0, 0, 0, 0, 0, 0, 0, 1),            8'b0010_0100);

        foreach (vecs[i]) begin
            apply(vecs[i].s);
            step();
            check(vecs[i].name, outs(), vecs[i].exp);
        end

        // watchdog on a stalled data read
        apply(mk(3, 1, 0, 0, 0, 0, 0, 0));
        step();
        apply(idle);
        for (int k = 1; k <= 9; k++) begin
            check($sformatf("wd_c%0d", k), outs(),
                  (k == 9) ? 8'b0100_0101 : 8'b0100_0100);
            if (k < 9) step();
        end
        apply(mk(0, 0, 3, 1, 0, 0, 0, 1));
        step();
        check("wd_clear", outs(), 8'b0010_0100);

        // asynchronous reset while waiting for B
        apply(mk(0, 0, 0, 0, 3, 0, 0, 0));
        step();
        apply(mk(0, 0, 0, 0, 0, 3, 0, 0));
        step();
        apply(idle);
        check("wr_resp", outs(), 8'b0010_1000);
        #3 rst_n = 1'b0;
        #1 check("rst_async", outs(), 8'b0010_0100);
        @(posedge clk);
        #2 rst_n = 1'b1;
        apply(mk(0, 0, 0, 0, 3, 0, 0, 0));
        step();
        check("aw_after_rst", outs(), 8'b0011_0000);

        // randomized traffic against the model
        apply(idle);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            s.ar   = {$urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1};
            s.arid = 4'($urandom_range(0, 15));
            s.r    = {$urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1};
            s.rid  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                 : {3'($urandom_range(0, 7)), m_rtag};
            s.aw   = {$urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1};
            s.w    = {$urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1};
            s.b    = {$urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1};
            s.clr  = $urandom_range(0, 15) == 0;
            apply(s);
            model_step(s);
            step();
            check($sformatf("rand_c%0d", c), outs(), model_outs());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
